// File: rtl/accum_sched_pkg.sv
// Shared definitions for the accumulation scheduler.
//   sched_state_t      : controller state (ACCUM collects a group, HOLD presents it)
//   GROUP_LEN_DEFAULT  : default number of beats per accumulation group
//   min_cnt_w()        : smallest counter width w with 2^w > group_len
package accum_sched_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } sched_state_t;

  localparam int GROUP_LEN_DEFAULT = 3;

  function automatic int min_cnt_w(input int group_len);
    int w;
    w = 1;
    while ((1 << w) <= group_len) w++;
    return w;
  endfunction

endpackage

// File: rtl/group_beat_counter.sv
// Beat counter for one accumulation group.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   clear      : force count to 0 (highest priority)
//   load1      : force count to 1 (first beat of a group taken during turnaround)
//   inc        : count + 1
//   count      : beats accepted so far in the current group
//   last       : count == GROUP_LEN-1, i.e. the next accepted beat closes the group
module group_beat_counter
  import accum_sched_pkg::*;
#(
  parameter int GROUP_LEN = GROUP_LEN_DEFAULT,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             load1,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // The counter only ever returns to 0 through clear; the FSM never lets it
  // run past GROUP_LEN-1, so it cannot overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load1) begin
      count <= CNT_W'(1);
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(GROUP_LEN - 1));

endmodule

// File: rtl/accum_scheduler.sv
// Sequencing controller for a bypassable adder/accumulator datapath.
// Collects GROUP_LEN beats per group, steering the datapath with adder_bypass
// (load first beat) and acc_en (capture every accepted beat), then presents the
// result on a valid/ready output with zero-bubble turnaround.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Valid, once raised, is held with stable payload until the transfer.
// in_ready depends combinationally on out_ready while a result is held.
//
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   in_valid      : upstream beat available (data lives in the datapath)
//   in_ready      : controller accepts a beat this cycle
//   adder_bypass  : datapath loads the beat instead of adding it
//   acc_en        : datapath accumulator captures this cycle
//   out_valid     : accumulator holds a finished group
//   out_ready     : downstream takes the result
//   beats         : beat count of the presented group (valid with out_valid)
//   flush         : close the current group early (ACCUM_SCHED_FLUSH_EN only)
//   state_dbg     : current FSM state (0 = ACCUM, 1 = HOLD)
// Optional feature macro: ACCUM_SCHED_FLUSH_EN
module accum_scheduler
  import accum_sched_pkg::*;
#(
  parameter int GROUP_LEN = GROUP_LEN_DEFAULT,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             adder_bypass,
  output logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] beats,
`ifdef ACCUM_SCHED_FLUSH_EN
  input  logic             flush,
`endif
  output logic             state_dbg
);

  if (CNT_W < min_cnt_w(GROUP_LEN)) begin : g_bad_cnt_w
    $error("accum_scheduler: CNT_W too small for GROUP_LEN");
  end

  sched_state_t     state, state_nxt;
  logic             out_valid_nxt;
  logic [CNT_W-1:0] beats_nxt;
  logic             cnt_clear, cnt_inc, cnt_load1;
  logic [CNT_W-1:0] count;
  logic             last;
  logic             fire_in, fire_out;

  group_beat_counter #(
    .GROUP_LEN(GROUP_LEN),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .load1(cnt_load1),
    .count(count),
    .last (last)
  );

  // Gating with reset keeps the datapath controls quiet while reset is held.
  // In HOLD, a beat is only taken when the result leaves in the same cycle,
  // so a stalled result is never overwritten.
  assign in_ready     = reset & ((state == ACCUM) | out_ready);
  assign fire_in      = in_valid & in_ready;
  assign fire_out     = out_valid & out_ready;
  assign acc_en       = fire_in;
  // Any beat accepted in HOLD is beat 0 of the next group.
  assign adder_bypass = fire_in & ((state == HOLD) | (count == '0));
  assign state_dbg    = state;

  always_comb begin
    state_nxt     = state;
    out_valid_nxt = out_valid;
    beats_nxt     = beats;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;
    cnt_load1     = 1'b0;
    case (state)
      ACCUM: begin
        if (fire_in && last) begin
          state_nxt     = HOLD;
          out_valid_nxt = 1'b1;
          beats_nxt     = CNT_W'(GROUP_LEN);
          cnt_clear     = 1'b1;
`ifdef ACCUM_SCHED_FLUSH_EN
        end else if (flush && (fire_in || count != '0)) begin
          // Early close; an empty group (no beats at all) is not presented.
          state_nxt     = HOLD;
          out_valid_nxt = 1'b1;
          beats_nxt     = count + CNT_W'(fire_in);
          cnt_clear     = 1'b1;
`endif
        end else if (fire_in) begin
          cnt_inc = 1'b1;
        end
      end
      HOLD: begin
        if (fire_in) begin
          // fire_in implies fire_out here: back-to-back turnaround.
          if (GROUP_LEN == 1) begin
            beats_nxt = CNT_W'(1);
          end else begin
            state_nxt     = ACCUM;
            out_valid_nxt = 1'b0;
            cnt_load1     = 1'b1;
          end
        end else if (fire_out) begin
          state_nxt     = ACCUM;
          out_valid_nxt = 1'b0;
          cnt_clear     = 1'b1;
        end
      end
      default: begin
        state_nxt     = ACCUM;
        out_valid_nxt = 1'b0;
        cnt_clear     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
      beats     <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      beats     <= beats_nxt;
    end
  end

endmodule

// File: tb/tb_accum_scheduler.sv
// Directed and randomized bench for accum_scheduler. A small datapath model
// (bypassable accumulator) is driven by the DUT's acc_en/adder_bypass; the bench
// computes expected group sums itself from the beats it hands over.
module tb_accum_scheduler;
  import accum_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // GROUP_LEN = 3 instance
  logic        reset, in_valid, out_ready, flush;
  logic        in_ready, adder_bypass, acc_en, out_valid, state_dbg;
  logic [7:0]  beats;
  logic [31:0] din, acc;

  // GROUP_LEN = 1 instance
  logic        in_valid1, out_ready1;
  logic        in_ready1, adder_bypass1, acc_en1, out_valid1, state_dbg1;
  logic [7:0]  beats1;
  logic [31:0] din1, acc1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  accum_scheduler #(.GROUP_LEN(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .adder_bypass(adder_bypass), .acc_en(acc_en), .out_valid(out_valid),
    .out_ready(out_ready), .beats(beats),
`ifdef ACCUM_SCHED_FLUSH_EN
    .flush(flush),
`endif
    .state_dbg(state_dbg)
  );

  accum_scheduler #(.GROUP_LEN(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .adder_bypass(adder_bypass1), .acc_en(acc_en1), .out_valid(out_valid1),
    .out_ready(out_ready1), .beats(beats1),
`ifdef ACCUM_SCHED_FLUSH_EN
    .flush(1'b0),
`endif
    .state_dbg(state_dbg1)
  );

  // Datapath models
  initial acc = '0;
  initial acc1 = '0;
  always @(posedge clk) if (acc_en) acc <= adder_bypass ? din : acc + din;
  always @(posedge clk) if (acc_en1) acc1 <= adder_bypass1 ? din1 : acc1 + din1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1; din = 32'd5; flush = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; din1 = '0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0d expected 0", in_ready); end
    checks++; if (acc_en !== 1'b0) begin errors++; $display("FAIL reset_acc_en: got %0d expected 0", acc_en); end
    checks++; if (adder_bypass !== 1'b0) begin errors++; $display("FAIL reset_bypass: got %0d expected 0", adder_bypass); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
    checks++; if (beats !== 8'd0) begin errors++; $display("FAIL reset_beats: got %0d expected 0", beats); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    tick();
    tick();
    reset = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; din = 32'(i + 1);
      @(negedge clk);
      checks++; if (adder_bypass !== (i == 0 || i == 3)) begin errors++; $display("FAIL b2b_bypass beat %0d: got %0d expected %0d", i, adder_bypass, (i == 0 || i == 3)); end
      checks++; if (out_valid !== (i == 3)) begin errors++; $display("FAIL b2b_out_valid beat %0d: got %0d expected %0d", i, out_valid, (i == 3)); end
      checks++; if (acc_en !== 1'b1) begin errors++; $display("FAIL b2b_acc_en beat %0d: got %0d expected 1", i, acc_en); end
      if (i == 3) begin
        checks++; if (acc !== 32'd6) begin errors++; $display("FAIL b2b_sum0: got %0d expected 6", acc); end
        checks++; if (beats !== 8'd3) begin errors++; $display("FAIL b2b_beats0: got %0d expected 3", beats); end
      end
      if (i == 4) begin
        checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL b2b_turnaround_state: got %0d expected 0", state_dbg); end
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid_end: got %0d expected 1", out_valid); end
    checks++; if (beats !== 8'd3) begin errors++; $display("FAIL b2b_beats1: got %0d expected 3", beats); end
    checks++; if (acc !== 32'd15) begin errors++; $display("FAIL b2b_sum1: got %0d expected 15", acc); end
    checks++; if (state_dbg !== 1'b1) begin errors++; $display("FAIL b2b_hold_state: got %0d expected 1", state_dbg); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", out_valid); end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; din = 32'(10 * (k + 1));
      tick();
    end
    din = 32'd40;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %0d expected 0", c, in_ready); end
      checks++; if (acc_en !== 1'b0) begin errors++; $display("FAIL stall_acc_en c%0d: got %0d expected 0", c, acc_en); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid c%0d: got %0d expected 1", c, out_valid); end
      checks++; if (beats !== 8'd3) begin errors++; $display("FAIL stall_beats c%0d: got %0d expected 3", c, beats); end
      checks++; if (acc !== 32'd60) begin errors++; $display("FAIL stall_acc c%0d: got %0d expected 60", c, acc); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0d expected 1", in_ready); end
    checks++; if (adder_bypass !== 1'b1) begin errors++; $display("FAIL release_bypass: got %0d expected 1", adder_bypass); end
    checks++; if (acc_en !== 1'b1) begin errors++; $display("FAIL release_acc_en: got %0d expected 1", acc_en); end
    tick();
    din = 32'd50;
    @(negedge clk);
    checks++; if (adder_bypass !== 1'b0) begin errors++; $display("FAIL release_beat1_bypass: got %0d expected 0", adder_bypass); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_beat1_out_valid: got %0d expected 0", out_valid); end
    tick();
    din = 32'd60;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL release_group_valid: got %0d expected 1", out_valid); end
    checks++; if (acc !== 32'd150) begin errors++; $display("FAIL release_group_sum: got %0d expected 150", acc); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1; din = 32'd7; tick();
    din = 32'd8; tick();
    din = 32'd9;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %0d expected 0", in_ready); end
    checks++; if (acc_en !== 1'b0) begin errors++; $display("FAIL midrst_acc_en: got %0d expected 0", acc_en); end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = 32'(k + 1);
      @(negedge clk);
      checks++; if (adder_bypass !== (k == 0)) begin errors++; $display("FAIL midrst_bypass beat %0d: got %0d expected %0d", k, adder_bypass, (k == 0)); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early_valid beat %0d: got %0d expected 0", k, out_valid); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_group_valid: got %0d expected 1", out_valid); end
    checks++; if (acc !== 32'd6) begin errors++; $display("FAIL midrst_group_sum: got %0d expected 6", acc); end
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %0d expected 0", out_valid); end
    checks++; if (beats !== 8'd0) begin errors++; $display("FAIL async_beats: got %0d expected 0", beats); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL async_state: got %0d expected 0", state_dbg); end
    tick();
    reset = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_group1();
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din1 = 32'(100 + i);
      @(negedge clk);
      checks++; if (adder_bypass1 !== 1'b1) begin errors++; $display("FAIL g1_bypass i%0d: got %0d expected 1", i, adder_bypass1); end
      checks++; if (out_valid1 !== (i > 0)) begin errors++; $display("FAIL g1_out_valid i%0d: got %0d expected %0d", i, out_valid1, (i > 0)); end
      if (i > 0) begin
        checks++; if (acc1 !== 32'(99 + i)) begin errors++; $display("FAIL g1_acc i%0d: got %0d expected %0d", i, acc1, 99 + i); end
        checks++; if (beats1 !== 8'd1) begin errors++; $display("FAIL g1_beats i%0d: got %0d expected 1", i, beats1); end
      end
      tick();
    end
    in_valid1 = 1'b0;
    @(negedge clk);
    checks++; if (acc1 !== 32'd104) begin errors++; $display("FAIL g1_last_acc: got %0d expected 104", acc1); end
    tick();
    @(negedge clk);
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL g1_drain: got %0d expected 0", out_valid1); end
    tick();
  endtask

`ifdef ACCUM_SCHED_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b1; flush = 1'b0;
    in_valid = 1'b1; din = 32'd1; tick();
    din = 32'd2; tick();
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_pre_valid: got %0d expected 0", out_valid); end
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush2_valid: got %0d expected 1", out_valid); end
    checks++; if (beats !== 8'd2) begin errors++; $display("FAIL flush2_beats: got %0d expected 2", beats); end
    checks++; if (acc !== 32'd3) begin errors++; $display("FAIL flush2_sum: got %0d expected 3", acc); end
    tick();
    in_valid = 1'b1; din = 32'd4; tick();
    din = 32'd5; flush = 1'b1; tick();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flushcc_valid: got %0d expected 1", out_valid); end
    checks++; if (beats !== 8'd2) begin errors++; $display("FAIL flushcc_beats: got %0d expected 2", beats); end
    checks++; if (acc !== 32'd9) begin errors++; $display("FAIL flushcc_sum: got %0d expected 9", acc); end
    tick();
    flush = 1'b1; tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %0d expected 0", out_valid); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic        pending, prev_stall;
    logic [7:0]  prev_beats;
    logic [31:0] prev_acc, sum, got;
    int          n;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    tick();
    reset = 1'b1;
    pending = 1'b0; prev_stall = 1'b0; prev_beats = '0; prev_acc = '0; sum = '0; n = 0;
    for (int c = 0; c < 10200; c++) begin
      if (c >= 10000) begin
        in_valid = 1'b0; out_ready = 1'b1;
      end else begin
        if (!pending) begin
          in_valid = 1'($urandom_range(0, 1));
          din = 32'($urandom_range(0, 255));
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || beats !== prev_beats || acc !== prev_acc) begin errors++; $display("FAIL rnd_stall_stable c%0d: got v=%0d b=%0d acc=%0d expected v=1 b=%0d acc=%0d", c, out_valid, beats, acc, prev_beats, prev_acc); end
      end
      if (out_valid && !out_ready) begin
        checks++; if (acc_en !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rnd_stall_accept c%0d: got acc_en=%0d in_ready=%0d expected 0,0", c, acc_en, in_ready); end
      end
      checks++; if (acc_en !== (in_valid & in_ready)) begin errors++; $display("FAIL rnd_acc_en c%0d: got %0d expected %0d", c, acc_en, in_valid & in_ready); end
      checks++; if (adder_bypass !== (in_valid & in_ready & (n == 0))) begin errors++; $display("FAIL rnd_bypass c%0d: got %0d expected %0d", c, adder_bypass, in_valid & in_ready & (n == 0)); end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_unexpected_result c%0d: got acc=%0d expected none", c, acc);
        end else begin
          got = exp_q.pop_front();
          checks++; if (acc !== got || beats !== 8'd3) begin errors++; $display("FAIL rnd_group_sum c%0d: got acc=%0d beats=%0d expected acc=%0d beats=3", c, acc, beats, got); end
        end
      end
      if (in_valid && in_ready) begin
        sum = sum + din; n++;
        if (n == 3) begin
          exp_q.push_back(sum); sum = '0; n = 0;
        end
        pending = 1'b0;
      end else begin
        pending = in_valid;
      end
      prev_stall = out_valid & ~out_ready;
      prev_beats = beats;
      prev_acc = acc;
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover: got %0d results pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_group1();
`ifdef ACCUM_SCHED_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_scheduler.md
# accum_scheduler

Sequencing controller for the bypassable adder/accumulator datapath. It accepts an input beat stream over a valid/ready handshake and drives the datapath controls: `adder_bypass` loads the first beat of each group, and `acc_en` captures every accepted beat. It presents the finished group result on an output valid/ready handshake with zero-bubble turnaround. It replaces free-running bypass timing with flow-controlled, backpressure-safe grouping.

## Interface
- `GROUP_LEN`, default 3: beats per accumulation group; legal range 1..255.
- `CNT_W`, default 8: width of the beat counter and `beats`; must satisfy `2^CNT_W > GROUP_LEN`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low (asserted when 0).
- `in_valid` in 1: upstream beat available; the datapath holds the beat's data.
- `in_ready` out 1: controller can accept a beat this cycle.
- `adder_bypass` out 1: datapath loads the beat instead of adding it.
- `acc_en` out 1: datapath accumulator register captures this cycle.
- `out_valid` out 1: accumulator holds a completed group.
- `out_ready` in 1: downstream takes the result.
- `beats` out `CNT_W`: number of beats in the presented group; valid while `out_valid`=1.
- `flush` in 1: present only with `ACCUM_SCHED_FLUSH_EN`.

## Operation
- FSM states:
  - ACCUM: collecting a group.
  - HOLD: result presented.
- Register reset values: state=ACCUM, `count`=0, `out_valid`=0, `beats`=0.
- While reset is asserted, `in_ready`=0, `acc_en`=0, `adder_bypass`=0.
- `acc_en` and `adder_bypass` are combinational (Mealy) so the datapath captures on the same edge as the handshake.
- Beat accepted (`fire_in`) = `in_valid & in_ready`; result taken (`fire_out`) = `out_valid & out_ready`.
- ACCUM:
  - `in_ready`=1; `acc_en`=`fire_in`; `adder_bypass`=`fire_in & (count==0)`.
  - On `fire_in` with `count < GROUP_LEN-1`: `count`++.
  - On `fire_in` with `count == GROUP_LEN-1`: go to HOLD, `out_valid`<=1, `beats`<=GROUP_LEN, `count`<=0.
- HOLD:
  - `in_ready`=`out_ready`, so no beat is accepted while the result is stalled.
  - A beat accepted in the same cycle as `fire_out` is beat 0 of the next group: `adder_bypass`=1, `acc_en`=1.
  - On `fire_out` without `fire_in`: go to ACCUM, `out_valid`<=0, `count`=0.
  - On `fire_out` with `fire_in` and GROUP_LEN>1: go to ACCUM, `count`<=1.
  - On `fire_out` with `fire_in` and GROUP_LEN==1: stay in HOLD, `out_valid` stays 1, `beats`<=1.
- The accumulator is never modified while `out_valid`=1 and `out_ready`=0.
- Counter arithmetic is unsigned `CNT_W`-bit. It wraps to 0 only by explicit load, never by overflow.
- Reset asserted mid-group: the partial group is discarded and `out_valid` drops immediately (asynchronous).

## Timing
- Latency: `out_valid` rises on the edge that accepts the last beat of a group.
- Sustained throughput is one beat per cycle when `out_ready`=1, with no bubble between groups.
- `in_ready` depends combinationally on `out_ready` in HOLD. No other input-to-output combinational paths exist, except `acc_en` and `adder_bypass` depending on `in_valid`.

## Configuration
- `ACCUM_SCHED_FLUSH_EN` defined:
  - Adds input `flush`.
  - In ACCUM, `flush`=1 closes the group: go to HOLD with `beats` = beats accepted including any beat accepted in that same cycle, and `count`<=0.
  - `flush` with `count`=0 and no `fire_in` is ignored.
  - `flush` in HOLD is ignored.
- Not defined: the port is absent and groups close only at GROUP_LEN.

## Structure
- Package `accum_sched_pkg` holds:
  - the state enum `sched_state_t` (ACCUM, HOLD);
  - the default `GROUP_LEN`;
  - a function computing the minimal `CNT_W`.
- Sub-module `group_beat_counter` provides the beat counter: `clear`, `inc`, `load1`, `count`, and a `last` flag for `count==GROUP_LEN-1`.

## Test plan
- Reset then 6 back-to-back beats with `out_ready`=1, GROUP_LEN=3:
  - `adder_bypass` high on beats 0 and 3;
  - `out_valid` high on the cycles after beats 2 and 5;
  - `beats`=3.
- `out_ready`=0 for 4 cycles after a group completes:
  - `in_ready`=0 and `acc_en`=0 throughout;
  - `out_valid` and `beats` stable;
  - on release, the next beat has `adder_bypass`=1.
- Simultaneous `fire_out` and `fire_in`: state goes to ACCUM with `count`=1 and no lost or duplicated beat. For GROUP_LEN=1, `out_valid` stays high every cycle.
- Reset asserted after 2 beats: outputs clear asynchronously; after release, the next beat has `adder_bypass`=1 and the group needs 3 fresh beats.
- `ACCUM_SCHED_FLUSH_EN`:
  - flush after 2 beats gives HOLD with `beats`=2;
  - flush concurrent with beat 1 gives `beats`=2;
  - flush with `count`=0 and no beat gives no `out_valid`.
- Random `in_valid`/`out_ready` (≥10k cycles): a scoreboard checks that the sum of each group of 3 matches the datapath output and that the handshake rules hold.
